jtag_tap: RTL



---
 rtl/jtag_tap_pkg.sv | 57 +++++
 rtl/jtag_tap_fsm.sv | 19 +
 rtl/jtag_tap.sv | 125 ++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the JTAG TAP: state encoding, instruction codes,
// the IR capture pattern and the 1149.1 next-state rule.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    // BYPASS is all ones; every code other than these two also selects BYPASS.
    localparam int INSTR_IDCODE = 1;
    localparam int INSTR_USER   = 8;

    // Loaded into the IR shifter at CAPTURE_IR: LSBs 01, zeros above.
    localparam int IR_CAPTURE_PAT = 1;

    localparam int IDCODE_LEN = 32;

    function automatic tap_state_t next_tap_state(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register: steps through the 16-state controller on every tck edge.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       tck,
    input  logic       rst,
    input  logic       tms,
    output tap_state_t state
);

    always_ff @(posedge tck) begin
        if (rst) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            state <= next_tap_state(state, tms);
        end
    end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP controller: instruction register plus IDCODE, BYPASS and USER
// data registers, with the tdo mux and USER handshake strobes.
module jtag_tap
    import jtag_tap_pkg::*;
#(
    parameter int          IR_LEN     = 4,
    parameter int          USER_LEN   = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h149511C3
) (
    input  logic                tck,
    input  logic                rst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [3:0]          tap_state,
    output logic [IR_LEN-1:0]   ir,
    input  logic [USER_LEN-1:0] user_capture_data,
    output logic                user_capture,
    output logic                user_shift,
    output logic                user_update,
    output logic [USER_LEN-1:0] user_update_data
);

    localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(INSTR_IDCODE);
    localparam logic [IR_LEN-1:0] IR_USER    = IR_LEN'(INSTR_USER);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(IR_CAPTURE_PAT);

    tap_state_t                state;
    logic [IR_LEN-1:0]         ir_shift;
    logic [IDCODE_LEN-1:0]     idcode_shift;
    logic                      bypass_reg;
    logic [USER_LEN-1:0]       user_reg;
    logic                      sel_idcode;
    logic                      sel_user;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .rst   (rst),
        .tms   (tms),
        .state (state)
    );

    assign tap_state  = state;
    assign sel_idcode = (ir == IR_IDCODE);
    assign sel_user   = (ir == IR_USER);

    // ir falls back to IDCODE on the same edge that enters TEST_LOGIC_RESET.
    always_ff @(posedge tck) begin
        if (rst) begin
            ir_shift <= '0;
            ir       <= IR_IDCODE;
        end else begin
            case (state)
                CAPTURE_IR: ir_shift <= IR_CAPTURE;
                SHIFT_IR:   ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};
                default:    ;
            endcase
            if (next_tap_state(state, tms) == TEST_LOGIC_RESET) begin
                ir <= IR_IDCODE;
            end else if (state == UPDATE_IR) begin
                ir <= ir_shift;
            end
        end
    end

    // Only the register selected by ir is captured or shifted; PAUSE and EXIT2 hold.
    always_ff @(posedge tck) begin
        if (rst) begin
            idcode_shift     <= '0;
            bypass_reg       <= 1'b0;
            user_reg         <= '0;
            user_update_data <= '0;
        end else begin
            case (state)
                CAPTURE_DR: begin
                    if (sel_idcode) begin
                        idcode_shift <= IDCODE_VAL;
                    end else if (sel_user) begin
                        user_reg <= user_capture_data;
                    end else begin
                        bypass_reg <= 1'b0;
                    end
                end
                SHIFT_DR: begin
                    if (sel_idcode) begin
                        idcode_shift <= {tdi, idcode_shift[IDCODE_LEN-1:1]};
                    end else if (sel_user) begin
                        user_reg <= (user_reg >> 1) | (USER_LEN'(tdi) << (USER_LEN - 1));
                    end else begin
                        bypass_reg <= tdi;
                    end
                end
                UPDATE_DR: begin
                    if (sel_user) begin
                        user_update_data <= user_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tdo_en = (state == SHIFT_IR) || (state == SHIFT_DR);

    always_comb begin
        tdo = 1'b0;
        if (state == SHIFT_IR) begin
            tdo = ir_shift[0];
        end else if (state == SHIFT_DR) begin
            if (sel_idcode) begin
                tdo = idcode_shift[0];
            end else if (sel_user) begin
                tdo = user_reg[0];
            end else begin
                tdo = bypass_reg;
            end
        end
    end

    assign user_capture = (state == CAPTURE_DR) && sel_user;
    assign user_shift   = (state == SHIFT_DR)   && sel_user;
    assign user_update  = (state == UPDATE_DR)  && sel_user;

endmodule
